// File: rtl/xmod_pkg.sv
`default_nettype none
// ============================================================================
// Module   : xmod_pkg
// Purpose  : Shared types, widths and result-shaping function for xmod_call_server.
// Revision : 1.0 - initial release
// ============================================================================
package xmod_pkg;

    localparam int C_NIN   = 8;
    localparam int C_NOUT  = 4;
    localparam int C_NTAG  = 4;
    localparam int C_SUM_W = C_NIN + 2;

    typedef struct packed {
        logic              ovf;
        logic [C_NTAG-1:0] tag;
        logic [C_NOUT-1:0] xout;
    } xmod_rsp_t;

    localparam int C_RSP_W = $bits(xmod_rsp_t);

    // Returns {ovf, xout}; xout is clamped when sat_en is set, else wrap-truncated.
    function automatic logic [C_NOUT:0] xmod_result(
        input logic signed [C_SUM_W-1:0] full,
        input logic                      sat_en
    );
        logic              under;
        logic              over;
        logic [C_NOUT-1:0] x;
        under = full[C_SUM_W-1];
        over  = !under && (full[C_SUM_W-2:C_NOUT] != '0);
        x     = full[C_NOUT-1:0];
        if (sat_en && under) begin
            x = '0;
        end else if (sat_en && over) begin
            x = '1;
        end
        return {under || over, x};
    endfunction

endpackage
`default_nettype wire

// File: rtl/xmod_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : xmod_rsp_fifo
// Purpose  : Circular response FIFO with wrap-around pointers; caller never overfills it.
// Revision : 1.0 - initial release
// ============================================================================
module xmod_rsp_fifo #(
    parameter  int WIDTH = 9,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CW-1:0]    o_count,
    output logic             o_empty
);

    localparam logic [PW-1:0] C_LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/xmod_call_server.sv
`default_nettype none
// ============================================================================
// Module   : xmod_call_server
// Purpose  : Handshaked XOUT = A + B - C call server (2-stage pipe + response FIFO).
//            Define XMOD_SAT_EN for saturating instead of truncating XOUT.
// Revision : 1.0 - initial release
// ============================================================================
module xmod_call_server
    import xmod_pkg::*;
#(
    parameter int NIN   = C_NIN,
    parameter int NOUT  = C_NOUT,
    parameter int NTAG  = C_NTAG,
    parameter int DEPTH = 4
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            REQ_VALID,
    output logic            REQ_READY,
    input  logic [NIN-1:0]  A,
    input  logic [NIN-1:0]  B,
    input  logic [NIN-1:0]  C,
    input  logic [NTAG-1:0] REQ_TAG,
    output logic            RSP_VALID,
    input  logic            RSP_READY,
    output logic [NOUT-1:0] XOUT,
    output logic [NTAG-1:0] RSP_TAG,
    output logic            RSP_OVF,
    output logic            BUSY
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] C_DEPTH_CNT = (CW + 1)'(DEPTH);

`ifdef XMOD_SAT_EN
    localparam logic C_SAT_EN = 1'b1;
`else
    localparam logic C_SAT_EN = 1'b0;
`endif

    logic                      r_s1_valid;
    logic signed [C_SUM_W-1:0] r_s1_full;
    logic [NTAG-1:0]           r_s1_tag;
    logic                      r_req_ready;

    logic                      w_accept;
    logic                      w_pop;
    logic                      w_empty;
    logic [CW-1:0]             w_count;
    logic [CW:0]               w_inflight_nxt;
    logic signed [C_SUM_W-1:0] w_full;
    logic [C_NOUT:0]           w_res;
    xmod_rsp_t                 w_push_data;
    logic [C_RSP_W-1:0]        w_head_bits;
    xmod_rsp_t                 w_head;

    assign w_accept = REQ_VALID && r_req_ready;
    assign w_pop    = !w_empty && RSP_READY;
    assign w_full   = $signed({2'b00, A}) + $signed({2'b00, B}) - $signed({2'b00, C});

    // Stage-1 content always fits: admission keeps s1_valid + count <= DEPTH.
    assign w_inflight_nxt = {1'b0, w_count} + {{CW{1'b0}}, r_s1_valid}
                          + {{CW{1'b0}}, w_accept} - {{CW{1'b0}}, w_pop};

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_s1_valid  <= 1'b0;
            r_s1_full   <= '0;
            r_s1_tag    <= '0;
            r_req_ready <= 1'b0;
        end else begin
            r_s1_valid  <= w_accept;
            r_req_ready <= (w_inflight_nxt < C_DEPTH_CNT);
            if (w_accept) begin
                r_s1_full <= w_full;
                r_s1_tag  <= REQ_TAG;
            end
        end
    end

    assign w_res       = xmod_result(r_s1_full, C_SAT_EN);
    assign w_push_data = '{ovf: w_res[C_NOUT], tag: r_s1_tag, xout: w_res[C_NOUT-1:0]};

    xmod_rsp_fifo #(
        .WIDTH (C_RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk     (CLK),
        .rst     (RST),
        .i_push  (r_s1_valid),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_head  (w_head_bits),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Memory is not reset, so the head is masked while the FIFO is empty.
    assign w_head    = w_head_bits;
    assign REQ_READY = r_req_ready;
    assign RSP_VALID = !w_empty;
    assign XOUT      = w_empty ? '0 : w_head.xout;
    assign RSP_TAG   = w_empty ? '0 : w_head.tag;
    assign RSP_OVF   = w_empty ? 1'b0 : w_head.ovf;
    assign BUSY      = r_s1_valid || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_xmod_call_server.sv
`default_nettype none
// ============================================================================
// Module   : tb_xmod_call_server
// Purpose  : Directed, table-driven self-checking bench for xmod_call_server.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xmod_call_server;

`ifdef XMOD_SAT_EN
    localparam bit C_SAT = 1'b1;
`else
    localparam bit C_SAT = 1'b0;
`endif

    logic       CLK;
    logic       RST;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [7:0] A;
    logic [7:0] B;
    logic [7:0] C;
    logic [3:0] REQ_TAG;
    logic       RSP_VALID;
    logic       RSP_READY;
    logic [3:0] XOUT;
    logic [3:0] RSP_TAG;
    logic       RSP_OVF;
    logic       BUSY;

    int n_vec = 0;
    int n_err = 0;

    xmod_call_server #(.NIN(8), .NOUT(4), .NTAG(4), .DEPTH(4)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .A         (A),
        .B         (B),
        .C         (C),
        .REQ_TAG   (REQ_TAG),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .XOUT      (XOUT),
        .RSP_TAG   (RSP_TAG),
        .RSP_OVF   (RSP_OVF),
        .BUSY      (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic [3:0] tag;
        logic [3:0] x_trunc;
        logic [3:0] x_sat;
        logic       ovf;
    } vec_t;

    vec_t vecs [11];

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: {ovf, tag, xout} computed with plain integer arithmetic.
    function automatic logic [8:0] exp_rsp(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c, input logic [3:0] tag);
        int         full;
        logic [3:0] x;
        logic       ovf;
        full = int'(a) + int'(b) - int'(c);
        ovf  = (full < 0) || (full > 15);
        if (C_SAT && full < 0)       x = 4'd0;
        else if (C_SAT && full > 15) x = 4'd15;
        else                         x = 4'(full & 15);
        return {ovf, tag, x};
    endfunction

    function automatic logic [8:0] act_rsp();
        return {RSP_OVF, RSP_TAG, XOUT};
    endfunction

    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                            input logic [3:0] tag, input logic [8:0] exp);
        RSP_READY = 1'b1;
        REQ_VALID = 1'b1;
        A = a; B = b; C = c; REQ_TAG = tag;
        chk("one_req_ready", 32'(REQ_READY), 32'd1);
        tick;
        REQ_VALID = 1'b0;
        chk("one_lat1_rsp_valid", 32'(RSP_VALID), 32'd0);
        tick;
        chk("one_lat2_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("one_rsp", 32'(act_rsp()), 32'(exp));
        tick;
        chk("one_idle_busy", 32'(BUSY), 32'd0);
    endtask

    task automatic run_stream(input int n);
        logic [8:0] q[$];
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        RSP_READY = 1'b1;
        while ((sent < n || got < n) && cyc < 200) begin
            if (RSP_VALID) begin
                if (q.size() == 0) begin
                    chk("stream_unexpected_rsp", 32'(act_rsp()), 32'h1ff);
                end else begin
                    chk("stream_rsp", 32'(act_rsp()), 32'(q.pop_front()));
                end
                got++;
            end
            if (sent < n) begin
                REQ_VALID = 1'b1;
                A = 8'((sent * 37) % 256);
                B = 8'((sent * 11) % 256);
                C = 8'((sent * 53) % 256);
                REQ_TAG = 4'(sent % 16);
                if (REQ_READY) begin
                    q.push_back(exp_rsp(A, B, C, REQ_TAG));
                    sent++;
                end
            end else begin
                REQ_VALID = 1'b0;
            end
            tick;
            cyc++;
        end
        REQ_VALID = 1'b0;
        chk("stream_got", 32'(got), 32'(n));
        chk("stream_cycles", 32'(cyc), 32'(n + 2));
    endtask

    initial begin
        int acc;
        int seen;

        vecs[0]  = '{8'd3,   8'd4,   8'd2,   4'd5,  4'd5,  4'd5,  1'b0};
        vecs[1]  = '{8'd200, 8'd100, 8'd17,  4'd1,  4'd11, 4'd15, 1'b1};
        vecs[2]  = '{8'd1,   8'd0,   8'd9,   4'd2,  4'd8,  4'd0,  1'b1};
        vecs[3]  = '{8'd0,   8'd0,   8'd0,   4'd3,  4'd0,  4'd0,  1'b0};
        vecs[4]  = '{8'd10,  8'd5,   8'd0,   4'd4,  4'd15, 4'd15, 1'b0};
        vecs[5]  = '{8'd10,  8'd6,   8'd0,   4'd6,  4'd0,  4'd15, 1'b1};
        vecs[6]  = '{8'd5,   8'd5,   8'd10,  4'd7,  4'd0,  4'd0,  1'b0};
        vecs[7]  = '{8'd0,   8'd0,   8'd1,   4'd8,  4'd15, 4'd0,  1'b1};
        vecs[8]  = '{8'd255, 8'd255, 8'd0,   4'd9,  4'd14, 4'd15, 1'b1};
        vecs[9]  = '{8'd0,   8'd0,   8'd255, 4'd10, 4'd1,  4'd0,  1'b1};
        vecs[10] = '{8'd100, 8'd0,   8'd90,  4'd15, 4'd10, 4'd10, 1'b0};

        RST = 1'b1; REQ_VALID = 1'b0; RSP_READY = 1'b0;
        A = '0; B = '0; C = '0; REQ_TAG = '0;

        // Reset hold and release
        tick;
        chk("rst_req_ready", 32'(REQ_READY), 32'd0);
        tick;
        RST = 1'b0;
        tick;
        chk("post_rst_req_ready", 32'(REQ_READY), 32'd1);
        chk("post_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("post_rst_busy", 32'(BUSY), 32'd0);
        chk("post_rst_rsp", 32'(act_rsp()), 32'd0);

        // Table of single calls
        for (int i = 0; i < 11; i++) begin
            send_one(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].tag,
                     {vecs[i].ovf, vecs[i].tag, C_SAT ? vecs[i].x_sat : vecs[i].x_trunc});
        end

        // Backpressure: only DEPTH requests admitted while consumer stalls
        RSP_READY = 1'b0;
        acc = 0;
        for (int t = 0; t < 6; t++) begin
            REQ_VALID = 1'b1;
            A = 8'(t); B = 8'd1; C = 8'd0; REQ_TAG = 4'(t);
            if (REQ_READY) acc++;
            tick;
        end
        REQ_VALID = 1'b0;
        chk("bp_accepted", 32'(acc), 32'd4);
        chk("bp_req_ready", 32'(REQ_READY), 32'd0);
        chk("bp_busy", 32'(BUSY), 32'd1);
        for (int s = 0; s < 3; s++) begin
            chk("bp_stall_valid", 32'(RSP_VALID), 32'd1);
            chk("bp_stall_rsp", 32'(act_rsp()), 32'(exp_rsp(8'd0, 8'd1, 8'd0, 4'd0)));
            tick;
        end
        RSP_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_drain_valid", 32'(RSP_VALID), 32'd1);
            chk("bp_drain_rsp", 32'(act_rsp()), 32'(exp_rsp(8'(k), 8'd1, 8'd0, 4'(k))));
            tick;
        end
        chk("bp_drained_busy", 32'(BUSY), 32'd0);
        send_one(8'd4, 8'd1, 8'd0, 4'd4, exp_rsp(8'd4, 8'd1, 8'd0, 4'd4));
        send_one(8'd5, 8'd1, 8'd0, 4'd5, exp_rsp(8'd5, 8'd1, 8'd0, 4'd5));

        // Streaming with pointer wrap-around
        run_stream(32);

        // Mid-operation reset discards in-flight requests
        RSP_READY = 1'b0;
        for (int t = 9; t < 12; t++) begin
            REQ_VALID = 1'b1;
            A = 8'd1; B = 8'd1; C = 8'd0; REQ_TAG = 4'(t);
            tick;
        end
        REQ_VALID = 1'b0;
        chk("mid_busy_before_rst", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick;
        chk("mid_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("mid_rst_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        RSP_READY = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick;
            if (RSP_VALID) seen++;
        end
        chk("mid_rst_no_stale", 32'(seen), 32'd0);
        run_stream(4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
